// File: rtl/avmm_cmd_master.sv
`default_nettype none
// ============================================================================
//  Module      : avmm_cmd_master
//  Description : Pops command packets from the host control FIFO, runs the
//                requested single-beat read/write transfers on an Avalon-MM
//                master port and pushes read data plus one status word per
//                command into the response FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
module avmm_cmd_master #(
  parameter int ADDR_INC    = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] cmd_d,
  input  logic        cmd_rdempty,
  output logic        cmd_rd,
  output logic [31:0] rsp_d,
  output logic        rsp_wr,
  input  logic        rsp_wrfull,
  output logic [31:0] avm_address,
  output logic        avm_read,
  input  logic [31:0] avm_readdata,
  output logic        avm_write,
  output logic [31:0] avm_writedata,
  input  logic        avm_waitrequest,
  output logic        busy
);

  localparam int          TW        = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [31:0] ADDR_STEP = 32'(ADDR_INC);

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_WRITE = 4'h1;
  localparam logic [3:0] OP_READ  = 4'h2;

  localparam logic [3:0] CODE_OK      = 4'h0;
  localparam logic [3:0] CODE_ILLEGAL = 4'h1;
  localparam logic [3:0] CODE_TIMEOUT = 4'h2;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_HDR_W  = 4'd1,
    S_ADR_RQ = 4'd2,
    S_ADR_W  = 4'd3,
    S_WD_RQ  = 4'd4,
    S_WD_W   = 4'd5,
    S_WR_BUS = 4'd6,
    S_RD_BUS = 4'd7,
    S_RD_RSP = 4'd8,
    S_STAT   = 4'd9,
    S_DR_RQ  = 4'd10,
    S_DR_W   = 4'd11
  } state_t;

  state_t          state, state_n;
  logic [3:0]      op, op_n;
  logic [3:0]      code, code_n;
  logic [7:0]      n_beats, n_beats_n;
  logic [7:0]      beats, beats_n;
  logic [7:0]      drain_left, drain_left_n;
  logic [TW-1:0]   tcnt, tcnt_n;
  logic [31:0]     addr_q, addr_n;
  logic [31:0]     wdata_q, wdata_n;
  logic [31:0]     rdata_q, rdata_n;
  logic            cmd_rd_c, rsp_wr_c;
  logic [7:0]      beats_inc;
  logic [7:0]      words_left;

  assign beats_inc  = beats + 8'd1;
  // Data words still queued in the command FIFO when the current write beat aborts.
  assign words_left = n_beats - beats_inc;

  // State and datapath registers; reset returns everything to an idle, zeroed master.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      op         <= 4'h0;
      code       <= 4'h0;
      n_beats    <= 8'h0;
      beats      <= 8'h0;
      drain_left <= 8'h0;
      tcnt       <= '0;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
      rdata_q    <= 32'h0;
    end else begin
      state      <= state_n;
      op         <= op_n;
      code       <= code_n;
      n_beats    <= n_beats_n;
      beats      <= beats_n;
      drain_left <= drain_left_n;
      tcnt       <= tcnt_n;
      addr_q     <= addr_n;
      wdata_q    <= wdata_n;
      rdata_q    <= rdata_n;
    end
  end

  // Next-state, datapath updates and bus/FIFO strobes.
  always_comb begin
    state_n      = state;
    op_n         = op;
    code_n       = code;
    n_beats_n    = n_beats;
    beats_n      = beats;
    drain_left_n = drain_left;
    tcnt_n       = tcnt;
    addr_n       = addr_q;
    wdata_n      = wdata_q;
    rdata_n      = rdata_q;
    cmd_rd_c     = 1'b0;
    rsp_wr_c     = 1'b0;
    avm_read     = 1'b0;
    avm_write    = 1'b0;

    case (state)
      S_IDLE: begin
        if (!cmd_rdempty) begin
          cmd_rd_c = 1'b1;
          state_n  = S_HDR_W;
        end
      end

      S_HDR_W: begin
        op_n      = cmd_d[31:28];
        n_beats_n = cmd_d[7:0];
        beats_n   = 8'h0;
        code_n    = CODE_OK;
        tcnt_n    = '0;
        case (cmd_d[31:28])
          OP_NOP:            state_n = S_STAT;
          OP_WRITE, OP_READ: state_n = S_ADR_RQ;
          default: begin
            // Unknown op: stop here so no further packet words are consumed.
            code_n  = CODE_ILLEGAL;
            state_n = S_STAT;
          end
        endcase
      end

      S_ADR_RQ: begin
        if (!cmd_rdempty) begin
          cmd_rd_c = 1'b1;
          state_n  = S_ADR_W;
        end
      end

      S_ADR_W: begin
        addr_n = cmd_d;
        if (n_beats == 8'h0)   state_n = S_STAT;
        else if (op == OP_READ) state_n = S_RD_BUS;
        else                    state_n = S_WD_RQ;
      end

      S_WD_RQ: begin
        if (!cmd_rdempty) begin
          cmd_rd_c = 1'b1;
          state_n  = S_WD_W;
        end
      end

      S_WD_W: begin
        wdata_n = cmd_d;
        state_n = S_WR_BUS;
      end

      S_WR_BUS: begin
        avm_write = 1'b1;
        if (!avm_waitrequest) begin
          tcnt_n  = '0;
          beats_n = beats_inc;
          addr_n  = addr_q + ADDR_STEP;
          state_n = (beats_inc == n_beats) ? S_STAT : S_WD_RQ;
        end else if (tcnt == TO_LAST) begin
          // Aborted beat is not counted; skip over the unsent data words.
          tcnt_n       = '0;
          code_n       = CODE_TIMEOUT;
          drain_left_n = words_left;
          state_n      = (words_left == 8'h0) ? S_STAT : S_DR_RQ;
        end else begin
          tcnt_n = tcnt + 1'b1;
        end
      end

      S_RD_BUS: begin
        avm_read = 1'b1;
        if (!avm_waitrequest) begin
          tcnt_n  = '0;
          rdata_n = avm_readdata;
          state_n = S_RD_RSP;
        end else if (tcnt == TO_LAST) begin
          tcnt_n  = '0;
          code_n  = CODE_TIMEOUT;
          state_n = S_STAT;
        end else begin
          tcnt_n = tcnt + 1'b1;
        end
      end

      S_RD_RSP: begin
        // The next read is held off until this word is in the response FIFO.
        if (!rsp_wrfull) begin
          rsp_wr_c = 1'b1;
          beats_n  = beats_inc;
          addr_n   = addr_q + ADDR_STEP;
          state_n  = (beats_inc == n_beats) ? S_STAT : S_RD_BUS;
        end
      end

      S_STAT: begin
        if (!rsp_wrfull) begin
          rsp_wr_c = 1'b1;
          state_n  = S_IDLE;
        end
      end

      S_DR_RQ: begin
        if (!cmd_rdempty) begin
          cmd_rd_c = 1'b1;
          state_n  = S_DR_W;
        end
      end

      S_DR_W: begin
        drain_left_n = drain_left - 8'd1;
        state_n      = (drain_left == 8'd1) ? S_STAT : S_DR_RQ;
      end

      default: state_n = S_IDLE;
    endcase
  end

  // FIFO strobes are suppressed while reset is held so nothing is lost or duplicated.
  assign cmd_rd        = cmd_rd_c & ~reset;
  assign rsp_wr        = rsp_wr_c & ~reset;
  assign rsp_d         = (state == S_STAT) ? {op, code, 16'h0, beats} : rdata_q;
  assign avm_address   = addr_q;
  assign avm_writedata = wdata_q;
  assign busy          = (state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_avmm_cmd_master.sv
`default_nettype none
// ============================================================================
//  Module      : tb_avmm_cmd_master
//  Description : Directed self-checking bench for avmm_cmd_master with a
//                command FIFO model, response log and Avalon-MM slave model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_avmm_cmd_master;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] cmd_d = 32'h0;
  logic        cmd_rdempty;
  logic        cmd_rd;
  logic [31:0] rsp_d;
  logic        rsp_wr;
  logic        rsp_wrfull = 1'b0;
  logic [31:0] avm_address;
  logic        avm_read;
  logic [31:0] avm_readdata;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic        avm_waitrequest;
  logic        busy;

  int checks = 0;
  int passes = 0;

  avmm_cmd_master #(.ADDR_INC(4), .TIMEOUT_CYC(8)) dut (
    .clk(clk), .reset(reset),
    .cmd_d(cmd_d), .cmd_rdempty(cmd_rdempty), .cmd_rd(cmd_rd),
    .rsp_d(rsp_d), .rsp_wr(rsp_wr), .rsp_wrfull(rsp_wrfull),
    .avm_address(avm_address), .avm_read(avm_read), .avm_readdata(avm_readdata),
    .avm_write(avm_write), .avm_writedata(avm_writedata),
    .avm_waitrequest(avm_waitrequest), .busy(busy)
  );

  always #5 clk = ~clk;

  // Command FIFO model: non-show-ahead, q valid the cycle after the read request.
  logic [31:0] cmd_mem [0:255];
  int wr_cnt = 0;
  int rd_ptr = 0;
  bit flush = 1'b0;
  assign cmd_rdempty = (rd_ptr == wr_cnt);
  always @(posedge clk) begin
    if (flush) rd_ptr <= wr_cnt;
    else if (cmd_rd) begin
      cmd_d  <= cmd_mem[rd_ptr];
      rd_ptr <= rd_ptr + 1;
    end
  end

  // Slave model: programmable wait states, stuck-high waitrequest, read data table.
  int wait_cycles = 0;
  bit stuck = 1'b0;
  int stuck_after = -1;
  int wcnt = 0;
  int beats_done = 0;
  int rd_idx = 0;
  logic [31:0] rd_tab [0:255];
  assign avm_waitrequest = stuck || (stuck_after >= 0 && beats_done >= stuck_after) || (wcnt < wait_cycles);
  assign avm_readdata = rd_tab[rd_idx];
  always @(posedge clk) begin
    if (reset) wcnt <= 0;
    else if (avm_read || avm_write) begin
      if (avm_waitrequest) wcnt <= wcnt + 1;
      else begin
        wcnt <= 0;
        beats_done <= beats_done + 1;
        if (avm_read) rd_idx <= rd_idx + 1;
      end
    end else wcnt <= 0;
  end

  // Transaction logs and protocol rule monitor.
  logic [31:0] wr_addr_log[$];
  logic [31:0] wr_data_log[$];
  logic [31:0] rd_addr_log[$];
  logic [31:0] rsp_log[$];
  int viol = 0;
  int wstall_cnt = 0;
  bit prev_stall = 1'b0;
  bit prev_cmd_rd = 1'b0;
  logic [31:0] prev_addr = 32'h0;
  logic [31:0] prev_data = 32'h0;
  always @(posedge clk) begin
    if (!reset) begin
      if (avm_write && !avm_waitrequest) begin
        wr_addr_log.push_back(avm_address);
        wr_data_log.push_back(avm_writedata);
      end
      if (avm_read && !avm_waitrequest) rd_addr_log.push_back(avm_address);
      if (rsp_wr) rsp_log.push_back(rsp_d);
      if (avm_write && avm_waitrequest) wstall_cnt++;
      if (rsp_wr && rsp_wrfull) viol++;
      if (avm_read && avm_write) viol++;
      if (cmd_rd && cmd_rdempty) viol++;
      if (cmd_rd && prev_cmd_rd) viol++;
      if (prev_stall && (avm_read || avm_write) &&
          (avm_address != prev_addr || (avm_write && avm_writedata != prev_data))) viol++;
    end
    prev_stall  = (avm_read || avm_write) && avm_waitrequest;
    prev_addr   = avm_address;
    prev_data   = avm_writedata;
    prev_cmd_rd = cmd_rd;
  end

  task automatic push(input logic [31:0] w);
    cmd_mem[wr_cnt] = w;
    wr_cnt++;
  endtask

  task automatic clear_logs();
    wr_addr_log.delete();
    wr_data_log.delete();
    rd_addr_log.delete();
    rsp_log.delete();
  endtask

  task automatic wait_rsp(input int n, input int budget, output bit ok);
    int k;
    k = 0;
    while (rsp_log.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    ok = (rsp_log.size() >= n);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passes++;
    checks++; if ({cmd_rd, rsp_wr, avm_read, avm_write} !== 4'b0000)
      $display("FAIL reset_strobes: got %b want 0000", {cmd_rd, rsp_wr, avm_read, avm_write}); else passes++;
    checks++; if ({avm_address, avm_writedata, rsp_d} !== 96'h0)
      $display("FAIL reset_data: got %h want 0", {avm_address, avm_writedata, rsp_d}); else passes++;
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_latency();
    int k;
    bit ok;
    clear_logs();
    push(32'h1000_0001); push(32'h0000_0040); push(32'h0000_00AB);
    k = 0;
    while (!avm_write && k < 50) begin
      @(negedge clk);
      k++;
    end
    checks++; if (k !== 6) $display("FAIL latency_hdr_to_write: got %0d want 6", k); else passes++;
    wait_rsp(1, 50, ok);
    checks++; if (!ok) $display("FAIL latency_rsp_wait: got %0d responses want 1", rsp_log.size()); else passes++;
    checks++; if (rsp_log[0] !== 32'h1000_0001) $display("FAIL latency_status: got %h want 10000001", rsp_log[0]); else passes++;
    checks++; if (wr_data_log[0] !== 32'hAB || wr_addr_log[0] !== 32'h40)
      $display("FAIL latency_write: got %h@%h want ab@40", wr_data_log[0], wr_addr_log[0]); else passes++;
  endtask

  task automatic test_write();
    bit ok;
    clear_logs();
    push(32'h1000_0003); push(32'h0000_0100);
    push(32'h11); push(32'h22); push(32'h33);
    wait_rsp(1, 100, ok);
    checks++; if (!ok) $display("FAIL write_rsp_wait: got %0d responses want 1", rsp_log.size()); else passes++;
    checks++; if (wr_addr_log.size() !== 3) $display("FAIL write_count: got %0d want 3", wr_addr_log.size()); else passes++;
    checks++; if ({wr_addr_log[0], wr_addr_log[1], wr_addr_log[2]} !== {32'h100, 32'h104, 32'h108})
      $display("FAIL write_addr: got %h %h %h want 100 104 108", wr_addr_log[0], wr_addr_log[1], wr_addr_log[2]); else passes++;
    checks++; if ({wr_data_log[0], wr_data_log[1], wr_data_log[2]} !== {32'h11, 32'h22, 32'h33})
      $display("FAIL write_data: got %h %h %h want 11 22 33", wr_data_log[0], wr_data_log[1], wr_data_log[2]); else passes++;
    checks++; if (rsp_log[0] !== 32'h1000_0003) $display("FAIL write_status: got %h want 10000003", rsp_log[0]); else passes++;
  endtask

  task automatic test_read();
    bit ok;
    clear_logs();
    wait_cycles = 3;
    rd_tab[rd_idx]     = 32'hDEAD_BEEF;
    rd_tab[rd_idx + 1] = 32'hCAFE_F00D;
    push(32'h2000_0002); push(32'h0000_0020);
    wait_rsp(3, 100, ok);
    wait_cycles = 0;
    checks++; if (!ok) $display("FAIL read_rsp_wait: got %0d responses want 3", rsp_log.size()); else passes++;
    checks++; if ({rsp_log[0], rsp_log[1], rsp_log[2]} !== {32'hDEAD_BEEF, 32'hCAFE_F00D, 32'h2000_0002})
      $display("FAIL read_rsp: got %h %h %h want deadbeef cafef00d 20000002", rsp_log[0], rsp_log[1], rsp_log[2]); else passes++;
    checks++; if ({rd_addr_log[0], rd_addr_log[1]} !== {32'h20, 32'h24})
      $display("FAIL read_addr: got %h %h want 20 24", rd_addr_log[0], rd_addr_log[1]); else passes++;
  endtask

  task automatic test_illegal();
    bit ok;
    int p0;
    clear_logs();
    p0 = rd_ptr;
    push(32'h7000_0005);
    push(32'h1000_0001); push(32'h0000_0200); push(32'h55);
    wait_rsp(2, 100, ok);
    checks++; if (!ok) $display("FAIL illegal_rsp_wait: got %0d responses want 2", rsp_log.size()); else passes++;
    checks++; if (rsp_log[0] !== 32'h7100_0000) $display("FAIL illegal_status: got %h want 71000000", rsp_log[0]); else passes++;
    checks++; if (rsp_log[1] !== 32'h1000_0001) $display("FAIL illegal_next_status: got %h want 10000001", rsp_log[1]); else passes++;
    checks++; if (wr_addr_log.size() !== 1 || wr_addr_log[0] !== 32'h200 || rd_addr_log.size() !== 0)
      $display("FAIL illegal_bus: got %0d writes first %h, %0d reads want 1 write at 200", wr_addr_log.size(), wr_addr_log[0], rd_addr_log.size()); else passes++;
    checks++; if (rd_ptr - p0 !== 4) $display("FAIL illegal_pops: got %0d want 4", rd_ptr - p0); else passes++;
  endtask

  task automatic test_zero();
    bit ok;
    clear_logs();
    push(32'h2000_0000); push(32'h0000_0010);
    wait_rsp(1, 50, ok);
    checks++; if (!ok || rsp_log[0] !== 32'h2000_0000) $display("FAIL zero_status: got %h want 20000000", rsp_log[0]); else passes++;
    checks++; if (rd_addr_log.size() !== 0) $display("FAIL zero_bus: got %0d reads want 0", rd_addr_log.size()); else passes++;
  endtask

  task automatic test_timeout();
    bit ok;
    int ws0;
    clear_logs();
    ws0 = wstall_cnt;
    stuck_after = beats_done + 1;
    push(32'h1000_0004); push(32'h0000_0300);
    push(32'hD1); push(32'hD2); push(32'hD3); push(32'hD4);
    wait_rsp(1, 200, ok);
    stuck_after = -1;
    checks++; if (!ok || rsp_log[0] !== 32'h1200_0001) $display("FAIL timeout_status: got %h want 12000001", rsp_log[0]); else passes++;
    checks++; if (wr_addr_log.size() !== 1 || wr_addr_log[0] !== 32'h300 || wr_data_log[0] !== 32'hD1)
      $display("FAIL timeout_writes: got %0d writes first %h@%h want 1 write d1@300", wr_addr_log.size(), wr_data_log[0], wr_addr_log[0]); else passes++;
    checks++; if (wstall_cnt - ws0 !== 8) $display("FAIL timeout_stall_cycles: got %0d want 8", wstall_cnt - ws0); else passes++;
    @(negedge clk);
    checks++; if (cmd_rdempty !== 1'b1 || busy !== 1'b0)
      $display("FAIL timeout_drained: got empty=%b busy=%b want empty=1 busy=0", cmd_rdempty, busy); else passes++;
  endtask

  task automatic test_backpressure();
    bit ok;
    int nread;
    int nwr;
    clear_logs();
    rd_tab[rd_idx]     = 32'hA000_0001;
    rd_tab[rd_idx + 1] = 32'hA000_0002;
    rd_tab[rd_idx + 2] = 32'hA000_0003;
    push(32'h2000_0003); push(32'h0000_0400);
    wait_rsp(1, 50, ok);
    rsp_wrfull = 1'b1;
    nread = 0;
    nwr = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (avm_read) nread++;
      if (rsp_wr) nwr++;
    end
    checks++; if (nread !== 0) $display("FAIL bp_read_while_full: got %0d want 0", nread); else passes++;
    checks++; if (nwr !== 0 || rsp_log.size() !== 1)
      $display("FAIL bp_write_while_full: got %0d strobes %0d logged want 0 and 1", nwr, rsp_log.size()); else passes++;
    rsp_wrfull = 1'b0;
    wait_rsp(4, 50, ok);
    checks++; if (!ok || {rsp_log[0], rsp_log[1], rsp_log[2]} !== {32'hA000_0001, 32'hA000_0002, 32'hA000_0003})
      $display("FAIL bp_data: got %h %h %h want a0000001 a0000002 a0000003", rsp_log[0], rsp_log[1], rsp_log[2]); else passes++;
    checks++; if (rsp_log[3] !== 32'h2000_0003) $display("FAIL bp_status: got %h want 20000003", rsp_log[3]); else passes++;
    checks++; if (rd_addr_log[2] !== 32'h408) $display("FAIL bp_addr: got %h want 408", rd_addr_log[2]); else passes++;
  endtask

  task automatic test_reset_mid();
    int k;
    clear_logs();
    stuck = 1'b1;
    push(32'h1000_0002); push(32'h0000_0500); push(32'hE1); push(32'hE2);
    k = 0;
    while (!avm_write && k < 50) begin
      @(negedge clk);
      k++;
    end
    repeat (2) @(negedge clk);
    checks++; if (avm_write !== 1'b1) $display("FAIL rstmid_setup: got avm_write=%b want 1", avm_write); else passes++;
    reset = 1'b1;
    @(negedge clk);
    checks++; if ({avm_write, busy, rsp_wr} !== 3'b000)
      $display("FAIL rstmid_strobes: got write=%b busy=%b rsp_wr=%b want 0 0 0", avm_write, busy, rsp_wr); else passes++;
    checks++; if ({avm_address, avm_writedata} !== 64'h0)
      $display("FAIL rstmid_data: got %h %h want 0 0", avm_address, avm_writedata); else passes++;
    flush = 1'b1;
    stuck = 1'b0;
    @(negedge clk);
    flush = 1'b0;
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_wrap();
    bit ok;
    clear_logs();
    push(32'h1000_0002); push(32'hFFFF_FFFC); push(32'hA1); push(32'hA2);
    wait_rsp(1, 100, ok);
    checks++; if (!ok || rsp_log[0] !== 32'h1000_0002) $display("FAIL wrap_status: got %h want 10000002", rsp_log[0]); else passes++;
    checks++; if ({wr_addr_log[0], wr_addr_log[1]} !== {32'hFFFF_FFFC, 32'h0})
      $display("FAIL wrap_addr: got %h %h want fffffffc 00000000", wr_addr_log[0], wr_addr_log[1]); else passes++;
    checks++; if (wr_data_log[1] !== 32'hA2) $display("FAIL wrap_data: got %h want a2", wr_data_log[1]); else passes++;
  endtask

  initial begin
    test_reset();
    test_latency();
    test_write();
    test_read();
    test_illegal();
    test_zero();
    test_timeout();
    test_backpressure();
    test_reset_mid();
    test_wrap();
    checks++; if (viol !== 0) $display("FAIL protocol_rules: got %0d violations want 0", viol); else passes++;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/avmm_cmd_master.md
Name: avmm_cmd_master

Overview:
- Host-side initiator for the CPU subsystem's Avalon-MM slave windows (avmm_s0/avmm_s1).
- Pops command packets from a host control FIFO (read side, normal non-show-ahead mode) and executes single or burst-of-single read/write transfers on an Avalon-MM master port.
- Pushes read data and one status word per command into a response FIFO (write side).
- Sits between the PCIe control stream FIFOs and one nios_cpu slave port.

Parameters:
- ADDR_INC, 4, address increment per beat (byte addressing).
- TIMEOUT_CYC, 1024, consecutive waitrequest-high cycles before a beat is aborted (min 2).

Ports:
- clk  in  1  single clock.
- reset  in  1  synchronous, active-high reset.
- cmd_d  in  32  command FIFO q; valid the cycle after cmd_rd.
- cmd_rdempty  in  1  command FIFO empty.
- cmd_rd  out  1  command FIFO read request, one-cycle pulse.
- rsp_d  out  32  response word.
- rsp_wr  out  1  response FIFO write strobe.
- rsp_wrfull  in  1  response FIFO full.
- avm_address  out  32  master address.
- avm_read  out  1  read request.
- avm_readdata  in  32  read data, valid when avm_read & !avm_waitrequest.
- avm_write  out  1  write request.
- avm_writedata  out  32  write data.
- avm_waitrequest  in  1  slave stall.
- busy  out  1  high whenever FSM is not in IDLE.

Behaviour:
- Reset (any cycle, including mid-transfer): next edge returns to IDLE. cmd_rd, rsp_wr, avm_read, avm_write and busy go to 0. avm_address, avm_writedata and rsp_d go to 0. Beat and timeout counters clear. A partially consumed packet is not resynchronised; the host re-flushes the FIFOs.
- Packet format:
  - Header: [31:28] op (1=WRITE, 2=READ, 0=NOP, others illegal), [27:8] ignored, [7:0] N = beat count.
  - Word 1: start address A.
  - WRITE only: N data words follow.
  - N=0: no bus access, status only.
- cmd_rd is asserted only when cmd_rdempty=0 and at most every other cycle. The FSM samples cmd_d in the following *_WAIT state.
- States:
  - IDLE: if !cmd_rdempty, pulse cmd_rd, go to HDR_W.
  - HDR_W: latch op and N. Illegal op goes to STAT with code 1; no further words are consumed. NOP goes to STAT with code 0. Otherwise go to ADR_RQ.
  - ADR_RQ: wait !cmd_rdempty, pulse cmd_rd, go to ADR_W.
  - ADR_W: latch A into avm_address. N=0 goes to STAT. READ goes to RD_BUS. WRITE goes to WD_RQ.
  - WD_RQ/WD_W: fetch one data word into avm_writedata, then go to WR_BUS.
  - WR_BUS: avm_write=1 until !avm_waitrequest. Then beats++ and address += ADR_INC (mod 2^32, wraps). If beats==N go to STAT, else go to WD_RQ.
  - RD_BUS: avm_read=1 until !avm_waitrequest. On that cycle capture avm_readdata into rsp_d, then go to RD_RSP.
  - RD_RSP: wait !rsp_wrfull, pulse rsp_wr, beats++ and advance address. If beats==N go to STAT, else go to RD_BUS.
  - STAT: rsp_d = {op, code[3:0], 16'h0, beats[7:0]}. Wait !rsp_wrfull, pulse rsp_wr, go to IDLE.
  - DRAIN: consume the remaining N-beats-1 write data words (rd/wait pairs, discarded), then go to STAT.
- avm_read and avm_write are never high together. Address and writedata are held stable while waitrequest=1.
- Timeout:
  - Counter increments each cycle avm_waitrequest=1 during a bus state and clears on beat completion.
  - When the counter reaches TIMEOUT_CYC, the request deasserts the next cycle, code=2, and the beat is not counted.
  - READ goes to STAT. WRITE goes to DRAIN, or directly to STAT if no words remain.
- Codes: 0=OK, 1=illegal op, 2=timeout.
- rsp_wr is never asserted while rsp_wrfull=1. Data words always precede the status word.
- Minimum latency for a 1-beat write with zero waitrequest and non-empty FIFOs: header to avm_write asserted is 6 cycles.

Test Plan:
- WRITE N=3, A=0x100, data 0x11/0x22/0x33, waitrequest=0 -> writes to 0x100, 0x104, 0x108 with matching data; one response 0x1000_0003.
- READ N=2, A=0x20, slave returns 0xDEADBEEF then 0xCAFEF00D after 3 waitrequest cycles each -> rsp 0xDEADBEEF, 0xCAFEF00D, 0x2000_0002.
- Header 0x7000_0005 -> no cmd_rd beyond the header, no bus activity; rsp 0x7100_0000; next packet is processed normally.
- WRITE N=4 with waitrequest stuck high from beat 2, TIMEOUT_CYC=8 -> avm_write drops after 8 cycles; 2 data words drained; rsp 0x1200_0001; FIFO empty afterwards.
- READ N=3 with rsp_wrfull held 20 cycles after the first data word -> no rsp_wr while full; no avm_read issued until the pending word is written; final rsp 0x2000_0003.
- Reset asserted mid-WR_BUS with waitrequest=1 -> next cycle avm_write=0, busy=0, rsp_wr=0; address wrap test A=0xFFFF_FFFC, N=2 -> second beat at 0x0000_0000.
